// File: rtl/mem_arbiter_pkg.sv
// Shared types for the RAM-port arbiter: word type, RAM handshake state,
// arbiter FSM state, and a helper for sizing the starvation counter.
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    // RAM handshake as reported by the memory model / controller.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter ownership of the RAM port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISERV = 2'd1,
        DSERV = 2'd2
    } arb_state_t;

    // Bits needed to count 0..limit inclusive (at least one bit).
    function automatic int scnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction, data and RAM-side signals around the arbiter.
// `arb` is the arbiter's view; `tb` is the requester/RAM side.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // instruction fetch path
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    // data memory path
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    // RAM port
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport arb (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// Registered arbiter sharing one RAM port between instruction fetch and
// data memory. Data wins by default; a saturating starvation counter forces
// an instruction grant after STARVE_LIMIT consecutive data grants made while
// a fetch was pending. Every serve state returns to IDLE before re-granting,
// so a retiring requester's stale request is never granted twice.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       CLK,
    input  logic       nRST,
    mem_arbiter_if.arb mif
);

    localparam int              CW    = scnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

    arb_state_t    state, state_nxt;
    logic [CW-1:0] scnt, scnt_nxt;

    logic dreq;      // any data request pending
    logic ram_done;  // RAM completes the current access this cycle
    logic starved;   // fetch pending and data has had its full run

    assign dreq     = mif.dREN | mif.dWEN;
    assign ram_done = (mif.ramstate == ACCESS);
    assign starved  = mif.iREN && (scnt == LIMIT);

    // State and starvation counter; reset abandons any transaction in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            scnt  <= '0;
        end else begin
            state <= state_nxt;
            scnt  <= scnt_nxt;
        end
    end

    // Next-state and counter update; grants only happen from IDLE.
    always_comb begin
        state_nxt = state;
        scnt_nxt  = scnt;
        case (state)
            IDLE: begin
                if (dreq && !starved) begin
                    state_nxt = DSERV;
                    if (mif.iREN)
                        scnt_nxt = (scnt == LIMIT) ? scnt : scnt + CW'(1);
                    else
                        scnt_nxt = '0;
                end else if (mif.iREN) begin
                    state_nxt = ISERV;
                    scnt_nxt  = '0;
                end
            end
            // Completion or the owner withdrawing both drop back to IDLE.
            // BUSY/FREE/ERROR hold so the access is retried.
            DSERV: if (ram_done || !dreq)     state_nxt = IDLE;
            ISERV: if (ram_done || !mif.iREN) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM steering and wait signals; enables follow the live request so an
    // abort removes them in the same cycle.
    always_comb begin
        mif.ramREN   = 1'b0;
        mif.ramWEN   = 1'b0;
        mif.ramaddr  = '0;
        mif.ramstore = '0;
        mif.iwait    = 1'b1;
        mif.dwait    = 1'b1;
        case (state)
            DSERV: begin
                mif.ramaddr  = mif.daddr;
                mif.ramstore = mif.dstore;
                mif.ramWEN   = mif.dWEN;
                mif.ramREN   = mif.dREN & ~mif.dWEN;  // write wins if both
                mif.dwait    = !ram_done;
            end
            ISERV: begin
                mif.ramaddr  = mif.iaddr;
                mif.ramREN   = mif.iREN;
                mif.iwait    = !ram_done;
            end
            default: ;
        endcase
    end

    // Read data is a straight pass-through; the wait signals qualify it.
    assign mif.iload = mif.ramload;
    assign mif.dload = mif.ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Stimulus scripts each scenario cycle by
// cycle and pushes the expected acknowledge (owner, cycle, RAM drive, load)
// into a scoreboard; a negedge monitor pops and compares whenever iwait or
// dwait goes low. Same-cycle properties are checked inline.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        bit    is_d;
        int    cyc;
        word_t addr;
        logic  ren;
        logic  wen;
        word_t store;
        word_t load;
    } exp_t;

    logic CLK;
    logic nRST;
    int   cyc;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];

    mem_arbiter_if mif();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .mif  (mif.arb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ack(input bit is_d, input int c, input word_t addr,
                              input logic ren, input logic wen,
                              input word_t store, input word_t load);
        exp_t e;
        e.is_d = is_d; e.cyc = c; e.addr = addr; e.ren = ren;
        e.wen = wen; e.store = store; e.load = load;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor: every low wait must match the next expected ack.
    always @(negedge CLK) begin
        if (nRST && (!mif.iwait || !mif.dwait)) begin
            check("one_owner", {31'd0, mif.iwait | mif.dwait}, 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_is_data", {31'd0, !mif.dwait}, {31'd0, e.is_d});
                check("ack_cycle",   cyc,                 e.cyc);
                check("ack_ramaddr", mif.ramaddr,         e.addr);
                check("ack_ramREN",  {31'd0, mif.ramREN}, {31'd0, e.ren});
                check("ack_ramWEN",  {31'd0, mif.ramWEN}, {31'd0, e.wen});
                check("ack_ramstore", mif.ramstore,       e.store);
                check("ack_load", e.is_d ? mif.dload : mif.iload, e.load);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        n_chk = 0; n_fail = 0; cyc = 0;
        nRST = 1'b0;
        mif.iREN = 0; mif.iaddr = '0;
        mif.dREN = 0; mif.dWEN = 0; mif.daddr = '0; mif.dstore = '0;
        mif.ramload = 32'h1234_5678; mif.ramstate = FREE;

        // Reset values while held.
        #2;
        check("rst_iwait",    {31'd0, mif.iwait},  32'd1);
        check("rst_dwait",    {31'd0, mif.dwait},  32'd1);
        check("rst_ramREN",   {31'd0, mif.ramREN}, 32'd0);
        check("rst_ramWEN",   {31'd0, mif.ramWEN}, 32'd0);
        check("rst_ramaddr",  mif.ramaddr,  32'd0);
        check("rst_ramstore", mif.ramstore, 32'd0);
        check("rst_iload",    mif.iload,    32'h1234_5678);
        check("rst_dload",    mif.dload,    32'h1234_5678);
        tick(); tick();
        nRST = 1'b1;
        tick();

        // Single fetch, immediate ACCESS.
        tick(); c = cyc;
        mif.iREN = 1; mif.iaddr = 32'h40;
        mif.ramstate = ACCESS; mif.ramload = 32'h8C22_0004;
        expect_ack(0, c + 1, 32'h40, 1, 0, 32'h0, 32'h8C22_0004);
        #3 check("fetch_idle_iwait",  {31'd0, mif.iwait},  32'd1);
           check("fetch_idle_ramREN", {31'd0, mif.ramREN}, 32'd0);
        tick();
        tick(); mif.iREN = 0;
        #3 check("fetch_after_iwait", {31'd0, mif.iwait}, 32'd1);

        // Simultaneous requests: data first, fetch two cycles later.
        tick(); c = cyc;
        mif.iREN = 1; mif.iaddr = 32'h80;
        mif.dREN = 1; mif.daddr = 32'h100; mif.dstore = 32'hA5A5_A5A5;
        mif.ramload = 32'h1111_2222;
        expect_ack(1, c + 1, 32'h100, 1, 0, 32'hA5A5_A5A5, 32'h1111_2222);
        expect_ack(0, c + 3, 32'h80,  1, 0, 32'h0,         32'h1111_2222);
        tick();
        tick(); mif.dREN = 0;
        tick();
        tick(); mif.iREN = 0;

        // Write with three BUSY cycles: five cycles of occupancy.
        tick(); c = cyc;
        mif.dWEN = 1; mif.daddr = 32'h200; mif.dstore = 32'hDEAD_BEEF;
        mif.ramstate = BUSY; mif.ramload = 32'h0BAD_F00D;
        expect_ack(1, c + 4, 32'h200, 0, 1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        for (int k = 1; k <= 3; k++) begin
            tick();
            #3 check("wr_busy_ramWEN",  {31'd0, mif.ramWEN}, 32'd1);
               check("wr_busy_ramaddr", mif.ramaddr, 32'h200);
               check("wr_busy_dwait",   {31'd0, mif.dwait}, 32'd1);
        end
        tick(); mif.ramstate = ACCESS;
        tick(); mif.dWEN = 0; mif.ramstate = FREE;
        #3 check("wr_done_dwait",  {31'd0, mif.dwait},  32'd1);
           check("wr_done_ramWEN", {31'd0, mif.ramWEN}, 32'd0);

        // Abort during BUSY, then a read+write (write wins) through ERROR.
        tick(); c = cyc;
        mif.dREN = 1; mif.daddr = 32'h400; mif.ramstate = BUSY;
        tick();
        #3 check("abort_busy_ramREN", {31'd0, mif.ramREN}, 32'd1);
        tick(); mif.dREN = 0;
        #3 check("abort_ramREN", {31'd0, mif.ramREN}, 32'd0);
           check("abort_dwait",  {31'd0, mif.dwait},  32'd1);
        tick();
        mif.dREN = 1; mif.dWEN = 1; mif.daddr = 32'h500; mif.dstore = 32'h600D_CAFE;
        mif.ramstate = ERROR; mif.ramload = 32'h7777_8888;
        expect_ack(1, c + 6, 32'h500, 0, 1, 32'h600D_CAFE, 32'h7777_8888);
        #3 check("abort_idle_ramWEN", {31'd0, mif.ramWEN}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            #3 check("err_dwait",  {31'd0, mif.dwait},  32'd1);
               check("err_ramWEN", {31'd0, mif.ramWEN}, 32'd1);
               check("err_ramREN", {31'd0, mif.ramREN}, 32'd0);
        end
        tick(); mif.ramstate = ACCESS;
        tick(); mif.dREN = 0; mif.dWEN = 0; mif.ramstate = FREE;

        // Starvation: four data grants, forced fetch, counter cleared, then
        // a reset mid-DSERV once the counter is saturated again.
        tick(); c = cyc;
        mif.iREN = 1; mif.iaddr = 32'h44;
        mif.dREN = 1; mif.daddr = 32'h300; mif.dstore = 32'h0;
        mif.ramstate = ACCESS; mif.ramload = 32'hCAFE_F00D;
        for (int k = 0; k < 4; k++)
            expect_ack(1, c + 1 + 2 * k, 32'h300, 1, 0, 32'h0, 32'hCAFE_F00D);
        expect_ack(0, c + 9, 32'h44, 1, 0, 32'h0, 32'hCAFE_F00D);
        for (int k = 0; k < 3; k++)
            expect_ack(1, c + 11 + 2 * k, 32'h300, 1, 0, 32'h0, 32'hCAFE_F00D);
        repeat (16) tick();
        mif.dREN = 0; mif.dWEN = 1; mif.daddr = 32'h310; mif.dstore = 32'h1212_1212;
        mif.ramstate = BUSY;
        tick();
        #2 check("rstmid_ramWEN_before", {31'd0, mif.ramWEN}, 32'd1);
        nRST = 1'b0;
        #1 check("rstmid_dwait",   {31'd0, mif.dwait},  32'd1);
           check("rstmid_ramWEN",  {31'd0, mif.ramWEN}, 32'd0);
           check("rstmid_ramaddr", mif.ramaddr, 32'h0);
        tick(); c = cyc;
        nRST = 1'b1; mif.ramstate = ACCESS;
        // Counter cleared by reset, so data wins over the pending fetch.
        expect_ack(1, c + 1, 32'h310, 0, 1, 32'h1212_1212, 32'hCAFE_F00D);
        tick();
        tick(); mif.iREN = 0; mif.dWEN = 0; mif.ramstate = FREE;
        tick(); tick();

        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
